// File: rtl/led_output_device.sv
// Memory-mapped LED output peripheral: a CPU store to BASE is held for HOLD_TIME
// cycles before reaching the LEDs; CTRL_BASE exposes ready, sticky overrun and ie.
module led_output_device #(
   parameter int             LED_WIDTH = 10,
   parameter int             BITS      = 32,
   parameter logic [BITS-1:0] BASE      = 32'hF0000004,
   parameter logic [BITS-1:0] CTRL_BASE = 32'hF0000104,
   parameter int             HOLD_TIME = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic                 re,
   input  logic [BITS-1:0]      memAddr,
   input  logic [BITS-1:0]      dataBusIn,
   output logic [BITS-1:0]      dataBusOut,
   output logic [LED_WIDTH-1:0] ledr,
   output logic                 intr
);

   localparam int CW = $clog2(HOLD_TIME) + 1;
   localparam logic [CW-1:0] LAST = CW'(HOLD_TIME - 1);

   typedef enum logic {IDLE, BUSY} stateT;

   stateT                state, stateNext;
   logic [CW-1:0]        counter, counterNext;
   logic [LED_WIDTH-1:0] pending, pendingNext;
   logic [LED_WIDTH-1:0] ledrNext;
   logic                 ready, readyNext;
   logic                 overrun, overrunNext;
   logic                 ie, ieNext;

   logic dataWr, ctrlWr, dataRd, ctrlRd;
   logic unusedBusBits;

   assign dataWr = we & (memAddr == BASE);
   assign ctrlWr = we & (memAddr == CTRL_BASE);
   assign dataRd = re & ~we & (memAddr == BASE);
   assign ctrlRd = re & ~we & (memAddr == CTRL_BASE);
   assign unusedBusBits = ^dataBusIn;

   assign intr = ready & ie;

   // All architectural state updates together; reset aborts any transfer in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         counter <= '0;
         pending <= '0;
         ledr    <= '0;
         ready   <= 1'b1;
         overrun <= 1'b0;
         ie      <= 1'b0;
      end else begin
         state   <= stateNext;
         counter <= counterNext;
         pending <= pendingNext;
         ledr    <= ledrNext;
         ready   <= readyNext;
         overrun <= overrunNext;
         ie      <= ieNext;
      end
   end

   // Next-state logic; a data store while BUSY (even on the completion cycle) is
   // dropped and only flags overrun.
   always_comb begin
      stateNext   = state;
      counterNext = counter;
      pendingNext = pending;
      ledrNext    = ledr;
      readyNext   = ready;
      overrunNext = overrun;
      ieNext      = ie;

      if (ctrlWr) begin
         ieNext = dataBusIn[8];
         if (!dataBusIn[2]) begin
            overrunNext = 1'b0;
         end
      end

      case (state)
         IDLE: begin
            if (dataWr) begin
               pendingNext = dataBusIn[LED_WIDTH-1:0];
               readyNext   = 1'b0;
               counterNext = '0;
               stateNext   = BUSY;
            end
         end
         BUSY: begin
            if (dataWr) begin
               overrunNext = 1'b1;
            end
            if (counter == LAST) begin
               ledrNext    = pending;
               readyNext   = 1'b1;
               counterNext = '0;
               stateNext   = IDLE;
            end else begin
               counterNext = counter + CW'(1);
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Read mux: the data register shows the displayed value, not the pending one.
   always_comb begin
      dataBusOut = '0;
      if (dataRd) begin
         dataBusOut[LED_WIDTH-1:0] = ledr;
      end else if (ctrlRd) begin
         dataBusOut[0] = ready;
         dataBusOut[2] = overrun;
         dataBusOut[8] = ie;
      end
   end

endmodule

// File: tb/tb_led_output_device.sv
// Directed bench for led_output_device: expected values are queued on a scoreboard
// and popped as the matching DUT output is sampled.
module tb_led_output_device;

   localparam logic [31:0] BASE      = 32'hF0000004;
   localparam logic [31:0] CTRL_BASE = 32'hF0000104;

   logic        clk;
   logic        reset;
   logic        we;
   logic        re;
   logic [31:0] memAddr;
   logic [31:0] dataBusIn;
   logic [31:0] dataBusOut;
   logic [9:0]  ledr;
   logic        intr;
   logic [31:0] dataBusOutFast;
   logic [9:0]  ledrFast;
   logic        intrFast;

   typedef struct {
      string       tag;
      logic [31:0] value;
   } expT;

   expT sbQ[$];
   int  passCount = 0;
   int  checkCount = 0;

   led_output_device #(.LED_WIDTH(10), .BITS(32), .BASE(BASE), .CTRL_BASE(CTRL_BASE),
                       .HOLD_TIME(4)) dut (
      .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(memAddr),
      .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .ledr(ledr), .intr(intr));

   led_output_device #(.LED_WIDTH(10), .BITS(32), .BASE(BASE), .CTRL_BASE(CTRL_BASE),
                       .HOLD_TIME(1)) dutFast (
      .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(memAddr),
      .dataBusIn(dataBusIn), .dataBusOut(dataBusOutFast), .ledr(ledrFast), .intr(intrFast));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a store from a falling edge so it is accepted on the next rising edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
      we        = 1'b1;
      memAddr   = addr;
      dataBusIn = data;
      @(posedge clk);
      @(negedge clk);
      we        = 1'b0;
      memAddr   = '0;
      dataBusIn = '0;
   endtask

   task automatic expectValue(input string tag, input logic [31:0] value);
      expT e;
      e.tag   = tag;
      e.value = value;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput(input logic [31:0] observed);
      expT e;
      checkCount++;
      if (sbQ.size() == 0) begin
         $error("[TB] FAIL scoreboard_empty observed=%h expected=<none>", observed);
      end else begin
         e = sbQ.pop_front();
         assert (observed === e.value) passCount++;
         else $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
      end
   endtask

   task automatic busRead(input logic [31:0] addr, input logic fast, output logic [31:0] value);
      re      = 1'b1;
      memAddr = addr;
      #1;
      value   = fast ? dataBusOutFast : dataBusOut;
      re      = 1'b0;
      memAddr = '0;
   endtask

   task automatic checkRead(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] v;
      expectValue(tag, exp);
      busRead(addr, 1'b0, v);
      checkOutput(v);
   endtask

   task automatic checkLed(input string tag, input logic [9:0] exp);
      expectValue(tag, {22'd0, exp});
      checkOutput({22'd0, ledr});
   endtask

   task automatic checkIntr(input string tag, input logic exp);
      expectValue(tag, {31'd0, exp});
      checkOutput({31'd0, intr});
   endtask

   initial begin
      logic [31:0] v;
      reset     = 1'b0;
      we        = 1'b0;
      re        = 1'b0;
      memAddr   = '0;
      dataBusIn = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] reset and idle");
      checkRead("rst_ctrl", CTRL_BASE, 32'h1);
      checkRead("rst_data", BASE, 32'h0);
      checkLed("rst_ledr", 10'h0);
      checkIntr("rst_intr", 1'b0);
      checkRead("unmapped_read", 32'hF0000008, 32'h0);

      $display("[TB] basic write");
      applyStimulus(BASE, 32'h000002A5);
      checkRead("busy_ctrl_n0", CTRL_BASE, 32'h0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         checkRead("busy_ctrl", CTRL_BASE, 32'h0);
         checkLed("busy_ledr", 10'h0);
      end
      @(negedge clk);
      checkLed("done_ledr", 10'h2A5);
      checkRead("done_ctrl", CTRL_BASE, 32'h1);
      checkRead("done_data", BASE, 32'h000002A5);

      $display("[TB] overrun");
      applyStimulus(BASE, 32'h00000001);
      @(negedge clk);
      applyStimulus(BASE, 32'h000003FF);
      @(negedge clk);
      @(negedge clk);
      checkLed("ovr_ledr", 10'h001);
      checkRead("ovr_ctrl", CTRL_BASE, 32'h5);
      repeat (5) @(negedge clk);
      checkLed("ovr_ledr_stays", 10'h001);
      applyStimulus(CTRL_BASE, 32'h0);
      checkRead("ovr_clear", CTRL_BASE, 32'h1);
      applyStimulus(BASE, 32'h00000002);
      applyStimulus(BASE, 32'h00000003);
      applyStimulus(CTRL_BASE, 32'h00000004);
      checkRead("ovr_write1_keeps", CTRL_BASE, 32'h4);
      @(negedge clk);
      @(negedge clk);
      checkRead("ovr_write1_done", CTRL_BASE, 32'h5);
      checkLed("ovr_write1_ledr", 10'h002);
      applyStimulus(CTRL_BASE, 32'h0);

      $display("[TB] completion-cycle collision");
      applyStimulus(BASE, 32'h000000F0);
      repeat (3) @(negedge clk);
      applyStimulus(BASE, 32'h0000000F);
      checkLed("coll_ledr", 10'h0F0);
      checkRead("coll_ctrl", CTRL_BASE, 32'h5);
      repeat (6) @(negedge clk);
      checkLed("coll_dropped", 10'h0F0);
      applyStimulus(CTRL_BASE, 32'h0);

      $display("[TB] interrupt");
      applyStimulus(CTRL_BASE, 32'h00000100);
      checkIntr("ie_intr", 1'b1);
      checkRead("ie_ctrl", CTRL_BASE, 32'h101);
      applyStimulus(BASE, 32'hFFFFFC3C);
      checkIntr("busy_intr_n0", 1'b0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         checkIntr("busy_intr", 1'b0);
      end
      @(negedge clk);
      checkIntr("done_intr", 1'b1);
      checkLed("hibits_ledr", 10'h03C);
      applyStimulus(CTRL_BASE, 32'h0);
      checkIntr("ie_off_intr", 1'b0);

      $display("[TB] reset mid-operation");
      applyStimulus(BASE, 32'h00000155);
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checkLed("arst_ledr", 10'h0);
      checkRead("arst_ctrl", CTRL_BASE, 32'h1);
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      checkLed("arst_ledr_stays", 10'h0);
      checkRead("arst_ctrl_stays", CTRL_BASE, 32'h1);

      $display("[TB] HOLD_TIME=1");
      applyStimulus(BASE, 32'h000002C3);
      expectValue("fast_busy_ledr", 32'h0);
      checkOutput({22'd0, ledrFast});
      expectValue("fast_busy_ctrl", 32'h0);
      busRead(CTRL_BASE, 1'b1, v);
      checkOutput(v);
      @(negedge clk);
      expectValue("fast_done_ledr", 32'h2C3);
      checkOutput({22'd0, ledrFast});
      expectValue("fast_done_ctrl", 32'h1);
      busRead(CTRL_BASE, 1'b1, v);
      checkOutput(v);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/led_output_device.md
Name: led_output_device

Overview:
Memory-mapped output peripheral that drives the board LEDs from the CPU data bus. It is the output-direction counterpart of the switch input device and uses the same register model: a data register at BASE and a control register at CTRL_BASE with ready, overrun and interrupt-enable bits. A CPU store to BASE is accepted into a pending latch. The LEDs update after a fixed hold delay, which models a slow output latch, and ready is then raised again. The block sits on the shared memory bus beside the other I/O devices.

Parameters:
LED_WIDTH, 10, number of LED outputs (1..BITS)
BITS, 32, bus address and data width
BASE, 32'hF0000004, data register address
CTRL_BASE, 32'hF0000104, control register address
HOLD_TIME, 4, cycles from an accepted data write to the LED update (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
we  input  1  CPU store strobe
re  input  1  CPU load strobe
memAddr  input  BITS  bus address
dataBusIn  input  BITS  store data from CPU
dataBusOut  output  BITS  load data to CPU (combinational)
ledr  output  LED_WIDTH  LED drive, registered
intr  output  1  interrupt request = ready & ie

Behaviour:
- Reset (reset=0, asynchronous): ledr=0, pending=0, state=IDLE, counter=0, ready=1, overrun=0, ie=0. Reset asserted during BUSY aborts the transfer; the pending value is discarded and never reaches ledr.
- Decodes:
  - dataWr = we & (memAddr==BASE)
  - ctrlWr = we & (memAddr==CTRL_BASE)
  - dataRd = re & !we & (memAddr==BASE)
  - ctrlRd = re & !we & (memAddr==CTRL_BASE)
  - we and re together count as a write.
- FSM states: IDLE, BUSY.
  - IDLE + dataWr: pending <= dataBusIn[LED_WIDTH-1:0], ready <= 0, counter <= 0, next state BUSY.
  - BUSY, counter < HOLD_TIME-1: counter <= counter+1.
  - BUSY, counter == HOLD_TIME-1: ledr <= pending, ready <= 1, counter <= 0, next state IDLE.
- Latency: a store accepted at edge N changes ledr at edge N+HOLD_TIME. With HOLD_TIME=1, ledr updates on the edge after acceptance.
- Overrun: dataWr while in BUSY, including the completion cycle, is dropped. Pending and ledr are unchanged and overrun <= 1.
- Control register layout:
  - bit0 ready: read-only.
  - bit2 overrun: sticky. ctrlWr with dataBusIn[2]=0 clears it; writing 1 has no effect.
  - bit8 ie: read/write via ctrlWr.
  - All other bits read 0.
- Simultaneous events: a data write and a control write cannot coincide (single address). Overrun set and overrun clear in the same cycle is impossible for the same reason.
- Reads:
  - dataRd returns zero-extended ledr, i.e. the displayed value, not pending.
  - ctrlRd returns the control register.
  - Otherwise dataBusOut=0.
  - Reads have no side effects on ready or overrun.
- intr is derived combinationally from registered ready and ie; it has no glitch source other than register outputs.
- Out-of-range store data: dataBusIn bits above LED_WIDTH-1 are ignored.
- counter width: clog2(HOLD_TIME)+1 bits. It never exceeds HOLD_TIME-1.

Test Plan:
- Reset then idle: release reset, read CTRL_BASE -> 0x00000001; read BASE -> 0; ledr=0, intr=0.
- Basic write, HOLD_TIME=4: store 0x2A5 to BASE at edge N -> ctrl reads 0x0 for edges N..N+3. At edge N+4, ledr=0x2A5 and ctrl=0x1; read BASE returns 0x000002A5.
- Overrun: store 0x001, then store 0x3FF two cycles later -> ledr becomes 0x001 only and ctrl=0x5. Store 0x0 to CTRL_BASE -> ctrl=0x1. A store of 0x4 to CTRL_BASE while overrun=1 leaves overrun=1.
- Completion-cycle collision: a second store exactly at counter==HOLD_TIME-1 -> ledr takes the first value, the second is dropped, overrun=1.
- Interrupt: store 0x100 to CTRL_BASE -> intr=1. Store to BASE -> intr=0 through the busy window, intr=1 at edge N+4. Store 0x0 to CTRL_BASE -> intr=0.
- Reset mid-operation: store 0x155, assert reset at edge N+2 -> ledr=0, ctrl=0x1 immediately (asynchronous). After release, ledr stays 0 indefinitely.
